// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_ctrl
//  Description : Multi-cycle sequencer that pushes WIDTH-bit operations
//                through one shared combinational 4-bit alu4 slice, LSB
//                slice first, one slice per cycle, carry chained between
//                slices. SLT runs a subtract pass followed by a set pass.
//  Ports       : clk/rst            clock, synchronous active-high reset
//                start_i/ready_o    issue handshake (accepted only in IDLE)
//                op_code_i          000 AND 001 OR 010 ADD 011 SUB
//                                   100 SLT 101 NOR 110 NAND 111 illegal
//                src_a_i/src_b_i    operands, sampled on accepted start
//                done_o             one-cycle completion pulse
//                result_o/cout_o/overflow_o/zero_o/illegal_o  results
//                alu_*_o            slice operands and controls to alu4
//                alu_result_i/alu_cout_i  alu4 outputs
//  Revision    : 1.0  initial release
// ============================================================================
module alu_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_code_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             cout_o,
    output logic             overflow_o,
    output logic             zero_o,
    output logic             illegal_o,
    output logic [3:0]       alu_src1_o,
    output logic [3:0]       alu_src2_o,
    output logic             alu_less_o,
    output logic             alu_A_invert_o,
    output logic             alu_B_invert_o,
    output logic             alu_cin_o,
    output logic [1:0]       alu_operation_o,
    input  logic [3:0]       alu_result_i,
    input  logic             alu_cout_i
);

    localparam int NSLICE = WIDTH / 4;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_SET  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_SLT  = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_NAND = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    logic [1:0]       state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [2:0]       op_q, op_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic             zero_q, zero_d, illegal_q, illegal_d, done_q, done_d;

    logic             running;
    logic             arith;
    logic [1:0]       dec_op;
    logic             dec_ainv, dec_binv, dec_cin0;
    logic [IDXW+1:0]  bit_base;

    assign running  = (state_q == S_RUN) || (state_q == S_SET);
    assign arith    = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_SLT);
    assign bit_base = {idx_q, 2'b00};

    // Opcode decode into alu4 controls; SET pass overrides the operation.
    always_comb begin
        dec_op   = 2'b00;
        dec_ainv = 1'b0;
        dec_binv = 1'b0;
        dec_cin0 = 1'b0;
        case (op_q)
            OP_AND:  dec_op = 2'b00;
            OP_OR:   dec_op = 2'b01;
            OP_ADD:  dec_op = 2'b10;
            OP_SUB, OP_SLT: begin
                dec_op   = 2'b10;
                dec_binv = 1'b1;
                dec_cin0 = 1'b1;
            end
            OP_NOR: begin
                dec_op   = 2'b00;
                dec_ainv = 1'b1;
                dec_binv = 1'b1;
            end
            OP_NAND: begin
                dec_op   = 2'b01;
                dec_ainv = 1'b1;
                dec_binv = 1'b1;
            end
            default: dec_op = 2'b00;
        endcase
        if (state_q == S_SET) begin
            dec_op   = 2'b11;
            dec_ainv = 1'b0;
            dec_binv = 1'b1;
        end
    end

    always_comb begin
        alu_src1_o      = 4'h0;
        alu_src2_o      = 4'h0;
        alu_less_o      = 1'b0;
        alu_A_invert_o  = 1'b0;
        alu_B_invert_o  = 1'b0;
        alu_cin_o       = 1'b0;
        alu_operation_o = 2'b00;
        if (running) begin
            alu_src1_o      = a_q[bit_base +: 4];
            alu_src2_o      = b_q[bit_base +: 4];
            alu_A_invert_o  = dec_ainv;
            alu_B_invert_o  = dec_binv;
            alu_operation_o = dec_op;
            alu_cin_o       = (idx_q == '0) ? dec_cin0 : carry_q;
            // result_q still holds the subtract difference when the set
            // bit is formed; sign corrected by the captured overflow.
            if ((state_q == S_SET) && (idx_q == '0)) begin
                alu_less_o = result_q[WIDTH-1] ^ ovf_q;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        result_d  = result_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    a_d       = src_a_i;
                    b_d       = src_b_i;
                    op_d      = op_code_i;
                    idx_d     = '0;
                    result_d  = '0;
                    carry_d   = 1'b0;
                    cout_d    = 1'b0;
                    ovf_d     = 1'b0;
                    zero_d    = 1'b0;
                    illegal_d = (op_code_i == OP_ILL);
                    if (op_code_i == OP_ILL) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        zero_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                result_d[bit_base +: 4] = alu_result_i;
                carry_d = alu_cout_i;
                if (idx_q == LAST_IDX) begin
                    idx_d  = '0;
                    cout_d = arith ? alu_cout_i : 1'b0;
                    ovf_d  = arith &&
                             (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ dec_binv)) &&
                             (alu_result_i[3] != a_q[WIDTH-1]);
                    if (op_q == OP_SLT) begin
                        state_d = S_SET;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        zero_d  = (result_d == '0);
                    end
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            S_SET: begin
                result_d[bit_base +: 4] = alu_result_i;
                carry_d = alu_cout_i;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    zero_d  = (result_d == '0);
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= 3'b000;
            result_q  <= '0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            result_q  <= result_d;
            carry_q   <= carry_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            done_q    <= done_d;
        end
    end

    assign ready_o    = (state_q == S_IDLE);
    assign done_o     = done_q;
    assign result_o   = result_q;
    assign cout_o     = cout_q;
    assign overflow_o = ovf_q;
    assign zero_o     = zero_q;
    assign illegal_o  = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq_ctrl
//  Description : Directed self-checking bench for alu_seq_ctrl (WIDTH=16)
//                with a behavioural alu4 slice model on the alu_* ports.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op_code;
    logic [15:0] src_a, src_b;
    logic        ready, done, cout, overflow, zero, illegal;
    logic [15:0] result;
    logic [3:0]  alu_src1, alu_src2, alu_result;
    logic        alu_less, alu_ainv, alu_binv, alu_cin, alu_cout;
    logic [1:0]  alu_operation;

    int nchk = 0;
    int errs = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.WIDTH(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start),
        .op_code_i      (op_code),
        .src_a_i        (src_a),
        .src_b_i        (src_b),
        .ready_o        (ready),
        .done_o         (done),
        .result_o       (result),
        .cout_o         (cout),
        .overflow_o     (overflow),
        .zero_o         (zero),
        .illegal_o      (illegal),
        .alu_src1_o     (alu_src1),
        .alu_src2_o     (alu_src2),
        .alu_less_o     (alu_less),
        .alu_A_invert_o (alu_ainv),
        .alu_B_invert_o (alu_binv),
        .alu_cin_o      (alu_cin),
        .alu_operation_o(alu_operation),
        .alu_result_i   (alu_result),
        .alu_cout_i     (alu_cout)
    );

    // Behavioural alu4: ripple of 1-bit cells, operation 11 passes less on bit 0.
    function automatic logic [4:0] alu4(input logic [3:0] a, input logic [3:0] b,
                                        input logic ai, input logic bi, input logic ci,
                                        input logic less, input logic [1:0] op);
        logic [3:0] r;
        logic       c, x, y, s;
        c = ci;
        r = 4'h0;
        for (int k = 0; k < 4; k++) begin
            x = a[k] ^ ai;
            y = b[k] ^ bi;
            s = x ^ y ^ c;
            case (op)
                2'b00:   r[k] = x & y;
                2'b01:   r[k] = x | y;
                2'b10:   r[k] = s;
                default: r[k] = (k == 0) ? less : 1'b0;
            endcase
            c = (x & y) | (x & c) | (y & c);
        end
        return {c, r};
    endfunction

    assign {alu_cout, alu_result} = alu4(alu_src1, alu_src2, alu_ainv, alu_binv,
                                         alu_cin, alu_less, alu_operation);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Issues one operation from an IDLE negedge and checks latency and outputs.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] er, input logic ec,
                         input logic ev, input logic eill, input int lat);
        int n;
        start   = 1'b1;
        op_code = op;
        src_a   = a;
        src_b   = b;
        @(negedge clk);
        n       = 1;
        start   = 1'b0;
        src_a   = ~a;
        src_b   = 16'h5A5A;
        op_code = 3'b110;
        chk({tag, " ready_busy"}, ready, 0);
        if (!eill) begin
            chk({tag, " src1_s0"}, alu_src1, a[3:0]);
            chk({tag, " src2_s0"}, alu_src2, b[3:0]);
        end
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, n, lat);
        chk({tag, " result"}, result, er);
        chk({tag, " cout"}, cout, ec);
        chk({tag, " ovf"}, overflow, ev);
        chk({tag, " zero"}, zero, (er == 16'h0));
        chk({tag, " illegal"}, illegal, eill);
        @(negedge clk);
        chk({tag, " done_1cyc"}, done, 0);
        chk({tag, " ready_idle"}, ready, 1);
    endtask

    initial begin
        int n;
        int ndone;
        logic [15:0] seen;
        rst = 1'b1; start = 1'b0; op_code = 3'b000; src_a = 16'h0; src_b = 16'h0;
        repeat (2) @(negedge clk);
        chk("rst ready", ready, 1);
        chk("rst done", done, 0);
        chk("rst result", result, 0);
        chk("rst flags", {cout, overflow, zero, illegal}, 0);
        chk("rst alu", {alu_src1, alu_src2, alu_less, alu_ainv, alu_binv, alu_cin, alu_operation}, 0);
        rst = 1'b0;
        @(negedge clk);

        do_op("add",   3'b010, 16'h00FF, 16'h0001, 16'h0100, 0, 0, 0, 5);
        do_op("sub1",  3'b011, 16'h0005, 16'h0007, 16'hFFFE, 0, 0, 0, 5);
        do_op("sub2",  3'b011, 16'h8000, 16'h0001, 16'h7FFF, 1, 1, 0, 5);
        do_op("slt1",  3'b100, 16'hFFFF, 16'h0001, 16'h0001, 1, 0, 0, 9);
        do_op("slt2",  3'b100, 16'h7FFF, 16'h8000, 16'h0000, 0, 1, 0, 9);
        do_op("and",   3'b000, 16'h0F0F, 16'h00FF, 16'h000F, 0, 0, 0, 5);
        do_op("or",    3'b001, 16'h0F0F, 16'h00FF, 16'h0FFF, 0, 0, 0, 5);
        do_op("nor",   3'b101, 16'h0F0F, 16'h00FF, 16'hF000, 0, 0, 0, 5);
        do_op("nand",  3'b110, 16'hFFFF, 16'hFFFF, 16'h0000, 0, 0, 0, 5);

        // start pulsed mid-RUN and during the done cycle must be ignored
        start = 1'b1; op_code = 3'b010; src_a = 16'h1234; src_b = 16'h1111;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; op_code = 3'b011; src_a = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        seen  = 16'h0;
        for (int k = 0; k < 14; k++) begin
            if (done) begin
                ndone++;
                seen  = result;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("ign done_count", ndone, 1);
        chk("ign result", seen, 16'h2345);
        chk("ign ready", ready, 1);

        // reset while slice 2 is on the alu
        start = 1'b1; op_code = 3'b010; src_a = 16'h0003; src_b = 16'h0004;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid ready", ready, 1);
        chk("rstmid done", done, 0);
        chk("rstmid result", result, 0);
        n = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) n++;
        end
        chk("rstmid no_done", n, 0);

        do_op("ill",   3'b111, 16'h1234, 16'h4321, 16'h0000, 0, 0, 1, 1);
        do_op("after", 3'b010, 16'h0001, 16'h0001, 16'h0002, 0, 0, 0, 5);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
`default_nettype wire
